// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V test-harness run controller.
// Holds the run FSM encoding, the default tohost address and a tohost decode helper.
package riscv_pkg;

    // Run controller state: hold the core in reset, let it run, or park it.
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } run_state_t;

    // Default word address of the software exit-code (tohost) register.
    localparam logic [31:0] TOHOST_ADDR_DFLT = 32'h0000_1000;

    // True when a snooped store is a qualifying exit write: it targets
    // tohost and carries the "finished" flag in bit 0.
    function automatic logic tohost_exit(
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] tohost
    );
        return we && (addr == tohost) && wdata[0];
    endfunction

endpackage

// File: rtl/riscv_run_counter.sv
// Free-running 32-bit event counter used for both hold and run timing.
// Ports: clk, rst (async high), i_clr (sync clear, wins over enable), i_en, o_q.
module riscv_run_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 32'd0;
        end else if (i_clr) begin
            r_q <= 32'd0;
        end else if (i_en) begin
            r_q <= r_q + 32'd1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Test-harness run controller: holds the core in reset, lets it run, snoops
// the tohost store for an exit code and enforces a run-cycle timeout.
// Ports: clk, rst (async high), restart (pulse, honoured only when done),
//        dmem_we/dmem_addr/dmem_wdata (snooped core stores),
//        core_rst_ (active-low core reset), done, pass, timeout,
//        exit_code[30:0], cycle_count[31:0]. All outputs are registered.
module riscv_run_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 200,
    parameter logic [31:0] TOHOST_ADDR     = TOHOST_ADDR_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        core_rst_,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [30:0] exit_code,
    output logic [31:0] cycle_count
);

    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD_CYCLES - 1);
    localparam logic [31:0] RUN_LAST  = 32'(TIMEOUT_CYCLES - 1);

    run_state_t  r_state;
    logic        r_core_rst_;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;
    logic [30:0] r_exit_code;

    logic [31:0] w_hold_q;
    logic [31:0] w_run_q;
    logic        w_hold_last;
    logic        w_run_last;
    logic        w_tohost;
    logic        w_restart;
    logic        w_hold_en;
    logic        w_hold_clr;
    logic        w_run_en;
    logic        w_run_clr;

    assign w_hold_last = (w_hold_q == HOLD_LAST);
    assign w_run_last  = (w_run_q == RUN_LAST);
    assign w_tohost    = tohost_exit(dmem_we, dmem_addr, dmem_wdata, TOHOST_ADDR);
    assign w_restart   = (r_state == ST_DONE) && restart;

    // Hold counter is cleared when leaving HOLD so a later restart always
    // starts the reset window from zero.
    assign w_hold_en  = (r_state == ST_HOLD);
    assign w_hold_clr = w_restart || (w_hold_en && w_hold_last);

    // Run counter also counts the edge that leaves RUN, then freezes in DONE.
    assign w_run_en  = (r_state == ST_RUN);
    assign w_run_clr = w_restart;

    riscv_run_counter u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_hold_clr),
        .i_en  (w_hold_en),
        .o_q   (w_hold_q)
    );

    riscv_run_counter u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_run_clr),
        .i_en  (w_run_en),
        .o_q   (w_run_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_core_rst_ <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exit_code <= 31'd0;
        end else begin
            unique case (r_state)
                ST_HOLD: begin
                    if (w_hold_last) begin
                        r_state     <= ST_RUN;
                        r_core_rst_ <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A qualifying exit write beats a timeout on the same edge.
                    if (w_tohost) begin
                        r_state     <= ST_DONE;
                        r_core_rst_ <= 1'b0;
                        r_done      <= 1'b1;
                        r_exit_code <= dmem_wdata[31:1];
                        r_pass      <= (dmem_wdata[31:1] == 31'd0);
                    end else if (w_run_last) begin
                        r_state     <= ST_DONE;
                        r_core_rst_ <= 1'b0;
                        r_done      <= 1'b1;
                        r_timeout   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        r_state     <= ST_HOLD;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_exit_code <= 31'd0;
                    end
                end
                default: begin
                    r_state     <= ST_HOLD;
                    r_core_rst_ <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_   = r_core_rst_;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign exit_code   = r_exit_code;
    assign cycle_count = w_run_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Self-checking bench for riscv_run_ctrl: vector table, directed corner
// sequences and randomized traffic against a run-level reference model.
module tb_riscv_run_ctrl;

    localparam int H = 4;
    localparam int T = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        core_rst_;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [30:0] exit_code;
    logic [31:0] cycle_count;

    riscv_run_ctrl #(
        .RST_HOLD_CYCLES (H),
        .TIMEOUT_CYCLES  (T),
        .TOHOST_ADDR     (32'h0000_1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .restart     (restart),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .core_rst_   (core_rst_),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .exit_code   (exit_code),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [66:0] w_obs;
    assign w_obs = {core_rst_, done, pass, timeout, exit_code, cycle_count};

    function automatic logic [66:0] ex(input logic cr, input logic d,
                                       input logic p, input logic to,
                                       input logic [30:0] code,
                                       input logic [31:0] cc);
        return {cr, d, p, to, code, cc};
    endfunction

    task automatic chk(input string nm, input logic [66:0] exp);
        n_total++;
        if (w_obs === exp) n_pass++;
        else $display("FAIL %s: got cr=%b d=%b p=%b to=%b code=%0d cc=%0d want cr=%b d=%b p=%b to=%b code=%0d cc=%0d",
                      nm, w_obs[66], w_obs[65], w_obs[64], w_obs[63], w_obs[62:32], w_obs[31:0],
                      exp[66], exp[65], exp[64], exp[63], exp[62:32], exp[31:0]);
    endtask

    // Reference model: time since the run started, plus a latched result.
    int          m_t;
    bit          m_fin;
    bit          m_pass;
    bit          m_to;
    logic [30:0] m_code;
    int          m_cc_fin;

    function automatic void model_reset();
        m_t = 0; m_fin = 0; m_pass = 0; m_to = 0; m_code = '0; m_cc_fin = 0;
    endfunction

    function automatic void model_edge();
        int k;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_fin) begin
            if (restart) model_reset();
            return;
        end
        if (m_t >= H) begin
            k = m_t - H;
            if (dmem_we && dmem_addr == 32'h1000 && dmem_wdata[0]) begin
                m_fin = 1; m_code = dmem_wdata[31:1];
                m_pass = (dmem_wdata[31:1] == 0); m_cc_fin = k + 1;
            end else if (k + 1 == T) begin
                m_fin = 1; m_to = 1; m_cc_fin = T;
            end
        end
        m_t++;
    endfunction

    function automatic logic [66:0] model_exp();
        logic run;
        run = !m_fin && (m_t >= H);
        return ex(run, m_fin, m_pass, m_to, m_code,
                  m_fin ? 32'(m_cc_fin) : (run ? 32'(m_t - H) : 32'd0));
    endfunction

    task automatic drive(input logic r, input logic rs, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        rst = r; restart = rs; dmem_we = we; dmem_addr = a; dmem_wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_run();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        idle();
        ticks(H);
    endtask

    typedef struct {
        logic        rst, restart, we;
        logic [31:0] addr, wdata;
        logic        cr, d, p, to;
        logic [30:0] code;
        logic [31:0] cc;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic r, input logic rs, input logic we,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic cr, input logic d, input logic p,
                                input logic to, input logic [30:0] code,
                                input logic [31:0] cc);
        vec_t v;
        v.rst = r; v.restart = rs; v.we = we; v.addr = a; v.wdata = wd;
        v.cr = cr; v.d = d; v.p = p; v.to = to; v.code = code; v.cc = cc;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(1, 0, 0, 32'h0,    32'h0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 32'h0,    32'h0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 32'h0,    32'h0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 32'h0,    32'h0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 32'h0,    32'h0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 32'h0,    32'h0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 32'h0,    32'h0, 1, 0, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 1, 32'h1000, 32'h6, 1, 0, 0, 0, 0, 2);
        tbl[8]  = mk(0, 0, 1, 32'h1004, 32'h1, 1, 0, 0, 0, 0, 3);
        tbl[9]  = mk(0, 1, 0, 32'h0,    32'h0, 1, 0, 0, 0, 0, 4);
        tbl[10] = mk(0, 0, 1, 32'h1000, 32'h7, 0, 1, 0, 0, 3, 5);
        tbl[11] = mk(0, 0, 0, 32'h0,    32'h0, 0, 1, 0, 0, 3, 5);
        tbl[12] = mk(0, 1, 0, 32'h0,    32'h0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 32'h0,    32'h0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 32'h0,    32'h0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 32'h0,    32'h0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 32'h0,    32'h0, 1, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 1, 32'h1000, 32'h1, 0, 1, 1, 0, 0, 1);

        model_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("reset_async", ex(0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].restart, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            tick();
            chk($sformatf("vec%0d", i),
                ex(tbl[i].cr, tbl[i].d, tbl[i].p, tbl[i].to, tbl[i].code, tbl[i].cc));
        end

        // Exit with pass on run cycle 50, then restart clears status.
        start_run();
        chk("run_start", ex(1, 0, 0, 0, 0, 0));
        ticks(49);
        chk("run_49", ex(1, 0, 0, 0, 0, 49));
        drive(1'b0, 1'b0, 1'b1, 32'h1000, 32'h1);
        tick();
        chk("pass_at_50", ex(0, 1, 1, 0, 0, 50));
        idle();
        ticks(3);
        chk("done_frozen", ex(0, 1, 1, 0, 0, 50));
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        chk("restart_clear", ex(0, 0, 0, 0, 0, 0));
        idle();

        // Timeout after exactly T run cycles.
        start_run();
        ticks(T - 1);
        chk("to_pre", ex(1, 0, 0, 0, 0, T - 1));
        tick();
        chk("timeout", ex(0, 1, 0, 1, 0, T));
        tick();
        chk("timeout_frozen", ex(0, 1, 0, 1, 0, T));

        // Tohost on the timeout edge wins.
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        idle();
        ticks(H);
        chk("rerun_start", ex(1, 0, 0, 0, 0, 0));
        ticks(T - 1);
        drive(1'b0, 1'b0, 1'b1, 32'h1000, 32'h1);
        tick();
        chk("tohost_beats_to", ex(0, 1, 1, 0, 0, T));
        idle();

        // Async reset mid-run.
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        idle();
        ticks(H + 30);
        chk("run_30", ex(1, 0, 0, 0, 0, 30));
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async", ex(0, 0, 0, 0, 0, 0));
        tick();
        chk("rst_held", ex(0, 0, 0, 0, 0, 0));
        idle();
        ticks(H - 1);
        chk("rehold", ex(0, 0, 0, 0, 0, 0));
        tick();
        chk("rehold_run", ex(1, 0, 0, 0, 0, 0));

        // Randomized traffic against the model.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        for (int c = 0; c < 4000; c++) begin
            logic        we;
            logic [31:0] a;
            logic [31:0] d;
            we = ($urandom % 3) == 0;
            a  = ($urandom % 100 == 0) ? 32'h1000 : ($urandom % 2 ? 32'h1004 : $urandom);
            d  = $urandom;
            if ($urandom % 2 == 0) d[31:4] = '0;
            drive(1'b0, ($urandom % 20) == 0, we, a, d);
            tick();
            chk("rnd", model_exp());
            if ($urandom % 600 == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                chk("rnd_rst", model_exp());
                tick();
                chk("rnd_rst_edge", model_exp());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/riscv_run_ctrl.md
RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 4, number of clk cycles core_rst_ is held low after rst release or restart (min 1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200, maximum RUN cycles before forced stop (min 1).
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, word address of the exit-code register.
REQ-004 SHALL have port clk, input, 1, single clock for all state.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port restart, input, 1, single-cycle pulse requesting a new run.
REQ-007 SHALL have port dmem_we, input, 1, core data-memory write strobe (snooped).
REQ-008 SHALL have port dmem_addr, input, 32, core data-memory write address.
REQ-009 SHALL have port dmem_wdata, input, 32, core data-memory write data.
REQ-010 SHALL have port core_rst_, output, 1, registered active-low reset to the core.
REQ-011 SHALL have port done, output, 1, run finished.
REQ-012 SHALL have port pass, output, 1, run finished with exit code 0.
REQ-013 SHALL have port timeout, output, 1, run ended by TIMEOUT_CYCLES.
REQ-014 SHALL have port exit_code, output, 31, code written by software.
REQ-015 SHALL have port cycle_count, output, 32, RUN cycles of the last or current run.

Function
REQ-016 SHALL implement FSM states HOLD, RUN, DONE; rst forces HOLD.
REQ-017 HOLD: core_rst_=0; hold counter increments each cycle; on count == RST_HOLD_CYCLES-1, next state RUN; core_rst_ low for exactly RST_HOLD_CYCLES edges after rst release.
REQ-018 RUN: core_rst_=1; cycle_count increments by 1 on every RUN edge, including the exiting edge.
REQ-019 RUN, dmem_we=1, dmem_addr==TOHOST_ADDR, dmem_wdata[0]=1: next state DONE, exit_code=dmem_wdata[31:1], pass=(dmem_wdata[31:1]==0), done=1.
REQ-020 tohost write with dmem_wdata[0]=0, or any write to another address: ignored.
REQ-021 RUN with cycle_count == TIMEOUT_CYCLES-1 and no qualifying tohost write: next state DONE, timeout=1, pass=0, exit_code unchanged (0).
REQ-022 Tohost write and timeout on the same edge: tohost wins, timeout=0.
REQ-023 DONE: core_rst_=0 (core re-held in reset); done, pass, timeout, exit_code, cycle_count frozen.
REQ-024 restart=1 in DONE: next state HOLD; clear done, pass, timeout, exit_code, cycle_count, hold counter on that edge.
REQ-025 restart in HOLD or RUN: ignored.
REQ-026 All outputs SHALL be registered; no combinational path from dmem_* to outputs.

Reset
REQ-027 rst assertion SHALL asynchronously force state=HOLD, core_rst_=0, done=0, pass=0, timeout=0, exit_code=0, cycle_count=0, hold counter=0.
REQ-028 rst asserted mid-RUN or in DONE SHALL abort the run with the same values; deassertion is sampled on clk, and HOLD timing restarts from the first edge after release.

Structure
REQ-029 State encoding and default TOHOST_ADDR SHALL live in shared package riscv_pkg.
REQ-030 Hold and run counting SHALL use one sub-module riscv_run_counter (32-bit, sync clear, enable, async reset).

Verification
REQ-031 rst high 2 cycles then low -> core_rst_=0 for exactly 4 edges, then 1; cycle_count starts incrementing.
REQ-032 RUN, at cycle 50 write 32'h0000_0001 to 32'h1000 -> next edge done=1, pass=1, exit_code=0, cycle_count=50, core_rst_=0.
REQ-033 Write 32'h0000_0007 to 32'h1000 -> done=1, pass=0, exit_code=3; write 32'h0000_0006 to 32'h1000 earlier -> ignored.
REQ-034 No tohost write -> after 200 RUN cycles done=1, timeout=1, pass=0, cycle_count=200; tohost write on cycle 200 instead -> timeout=0.
REQ-035 DONE then restart pulse -> status cleared, 4 HOLD cycles, new RUN; restart during RUN -> no effect.
REQ-036 rst pulse at RUN cycle 30 -> all outputs 0 immediately (async), HOLD restarts after release.
